// File: rtl/vga_pattern_core.sv
// vga_pattern_core
//   Free-running VGA timing generator with four built-in test patterns.
//   Line layout: sync, back porch, active, front porch (same order vertically).
//   Every output is registered one clock after the counter state it describes.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   asynchronous active-low reset
//   mode         in   pattern select: 0 bars, 1 grid, 2 solid, 3 checker
//   solid_rgb    in   {R,G,B} colour used by mode 2
//   R, G, B      out  pixel colour (zero outside the active area)
//   HSYNC, VSYNC out  sync outputs, active level = SYNC_POL
//   de           out  data enable, high on active pixels
//   pixel_x/y    out  coordinate of the pixel on R/G/B (zero outside active)
//   frame_start  out  one-clock pulse on the first clock of each frame
module vga_pattern_core #(
  parameter int H_DISP   = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_DISP   = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int R_W      = 5,
  parameter int G_W      = 6,
  parameter int B_W      = 5,
  parameter int SYNC_POL = 0,
  localparam int PW      = R_W + G_W + B_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    mode,
  input  logic [PW-1:0] solid_rgb,
  output logic [R_W-1:0] R,
  output logic [G_W-1:0] G,
  output logic [B_W-1:0] B,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          de,
  output logic [10:0]   pixel_x,
  output logic [10:0]   pixel_y,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int H_ACT_S = H_SYNC + H_BP;
  localparam int H_ACT_E = H_ACT_S + H_DISP;
  localparam int V_ACT_S = V_SYNC + V_BP;
  localparam int V_ACT_E = V_ACT_S + V_DISP;
  // Bar width; guarded so a display narrower than 8 pixels cannot divide by 0.
  localparam int BW      = (H_DISP >= 8) ? (H_DISP / 8) : 1;
  localparam logic POL   = (SYNC_POL != 0);

  logic [10:0]   h_cnt;
  logic [10:0]   v_cnt;
  logic [1:0]    mode_lat;
  logic [PW-1:0] solid_lat;

  logic          h_wrap;
  logic          v_wrap;
  logic          h_active;
  logic          v_active;
  logic          active;
  logic [10:0]   x;
  logic [10:0]   y;
  logic [10:0]   bar_q;
  logic [2:0]    bar;
  logic [PW-1:0] rgb_next;

  assign h_wrap = (h_cnt == 11'(H_TOTAL - 1));
  assign v_wrap = (v_cnt == 11'(V_TOTAL - 1));

  // 12-bit compares so a total of exactly 2048 still works at the upper bound.
  assign h_active = ({1'b0, h_cnt} >= 12'(H_ACT_S)) && ({1'b0, h_cnt} < 12'(H_ACT_E));
  assign v_active = ({1'b0, v_cnt} >= 12'(V_ACT_S)) && ({1'b0, v_cnt} < 12'(V_ACT_E));
  assign active   = h_active && v_active;

  assign x = h_cnt - 11'(H_ACT_S);
  assign y = v_cnt - 11'(V_ACT_S);

  // Remainder pixels past 8*BW are folded into the last bar.
  assign bar_q = x / 11'(BW);
  assign bar   = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];

  // Counters and the per-frame latch of the pattern controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      mode_lat  <= '0;
      solid_lat <= '0;
    end else begin
      if (h_cnt == 11'd0 && v_cnt == 11'd0) begin
        mode_lat  <= mode;
        solid_lat <= solid_rgb;
      end
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  // Bar colours follow the classic order white, yellow, cyan, green, magenta,
  // red, blue, black: R is off for bars 2,3,6,7 (bit1), G for 4..7 (bit2),
  // B for odd bars (bit0).
  always_comb begin
    rgb_next = '0;
    if (active) begin
      case (mode_lat)
        2'd0: rgb_next = {{R_W{~bar[1]}}, {G_W{~bar[2]}}, {B_W{~bar[0]}}};
        2'd1: if (x[4:0] == 5'd0 || y[4:0] == 5'd0 ||
                  x == 11'(H_DISP - 1) || y == 11'(V_DISP - 1))
                rgb_next = '1;
        2'd2: rgb_next = solid_lat;
        default: if (x[4] ^ y[4]) rgb_next = '1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R           <= '0;
      G           <= '0;
      B           <= '0;
      HSYNC       <= ~POL;
      VSYNC       <= ~POL;
      de          <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
    end else begin
      R           <= rgb_next[PW-1 -: R_W];
      G           <= rgb_next[B_W +: G_W];
      B           <= rgb_next[B_W-1:0];
      HSYNC       <= ({1'b0, h_cnt} < 12'(H_SYNC)) ? POL : ~POL;
      VSYNC       <= ({1'b0, v_cnt} < 12'(V_SYNC)) ? POL : ~POL;
      de          <= active;
      pixel_x     <= active ? x : 11'd0;
      pixel_y     <= active ? y : 11'd0;
      frame_start <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end
  end

endmodule

// File: tb/tb_vga_pattern_core.sv
// Testbench for vga_pattern_core. Two instances run side by side:
//   dut_a: reduced timing (144 x 41 clocks, active 128 x 36), active-low sync
//   dut_b: tiny timing (18 x 7 clocks, active 12 x 4), active-high sync
// A cycle-indexed reference model pushes one expected output vector per clock
// into a queue per instance; each test pops and compares after the edge.
module tb_vga_pattern_core;

  typedef logic [41:0] vec_t;  // {fs, hsync, vsync, de, px[11], py[11], rgb[16]}
  typedef struct {
    int hs, hb, hd, hf, vs, vb, vd, vf;
    bit pol;
  } cfg_t;

  localparam int FA = 144 * 41;
  localparam int FB = 18 * 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0000;

  logic [4:0]  r_a, b_a, r_b, b_b;
  logic [5:0]  g_a, g_b;
  logic        hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
  logic [10:0] px_a, py_a, px_b, py_b;
  vec_t        obs_a, obs_b;

  int vectors = 0;
  int miscompares = 0;

  cfg_t        cfg [2];
  int          mh [2];
  int          mv [2];
  logic [1:0]  lm [2];
  logic [15:0] ls [2];
  vec_t        qa [$];
  vec_t        qb [$];

  always #5 clk = ~clk;

  vga_pattern_core #(
    .H_DISP(128), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_DISP(36), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .R_W(5), .G_W(6), .B_W(5), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .R(r_a), .G(g_a), .B(b_a), .HSYNC(hs_a), .VSYNC(vs_a), .de(de_a),
    .pixel_x(px_a), .pixel_y(py_a), .frame_start(fs_a)
  );

  vga_pattern_core #(
    .H_DISP(12), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_DISP(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .R_W(5), .G_W(6), .B_W(5), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .mode(mode), .solid_rgb(solid_rgb),
    .R(r_b), .G(g_b), .B(b_b), .HSYNC(hs_b), .VSYNC(vs_b), .de(de_b),
    .pixel_x(px_b), .pixel_y(py_b), .frame_start(fs_b)
  );

  assign obs_a = {fs_a, hs_a, vs_a, de_a, px_a, py_a, r_a, g_a, b_a};
  assign obs_b = {fs_b, hs_b, vs_b, de_b, px_b, py_b, r_b, g_b, b_b};

  function automatic vec_t rst_vec(bit pol);
    vec_t v = '0;
    v[40] = !pol;
    v[39] = !pol;
    return v;
  endfunction

  function automatic vec_t predict(cfg_t c, int h, int v, logic [1:0] md, logic [15:0] sol);
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int x, y, bar;
    bit act, hs, vs, fs;
    logic [15:0] rgb = 16'h0000;
    logic [10:0] px = '0, py = '0;
    hs  = (h < c.hs) ? c.pol : !c.pol;
    vs  = (v < c.vs) ? c.pol : !c.pol;
    act = (h >= c.hs + c.hb) && (h < c.hs + c.hb + c.hd) &&
          (v >= c.vs + c.vb) && (v < c.vs + c.vb + c.vd);
    fs  = (h == 0) && (v == 0);
    if (act) begin
      x  = h - (c.hs + c.hb);
      y  = v - (c.vs + c.vb);
      px = 11'(x);
      py = 11'(y);
      case (md)
        2'd0: begin
          bar = x / (c.hd / 8);
          if (bar > 7) bar = 7;
          rgb = bars[bar];
        end
        2'd1: if (x % 32 == 0 || y % 32 == 0 || x == c.hd - 1 || y == c.vd - 1) rgb = 16'hFFFF;
        2'd2: rgb = sol;
        default: if (((x / 16) % 2) != ((y / 16) % 2)) rgb = 16'hFFFF;
      endcase
    end
    return {fs, hs, vs, act, px, py, rgb};
  endfunction

  // Push the expectation for the counter state registered at the next edge,
  // advance the model, then wait past that edge.
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      vec_t e;
      if (!rst_n) begin
        e = rst_vec(cfg[k].pol);
        mh[k] = 0; mv[k] = 0; lm[k] = 2'd0; ls[k] = 16'h0000;
      end else begin
        e = predict(cfg[k], mh[k], mv[k], lm[k], ls[k]);
        if (mh[k] == 0 && mv[k] == 0) begin
          lm[k] = mode;
          ls[k] = solid_rgb;
        end
        mh[k]++;
        if (mh[k] == cfg[k].hs + cfg[k].hb + cfg[k].hd + cfg[k].hf) begin
          mh[k] = 0;
          mv[k]++;
          if (mv[k] == cfg[k].vs + cfg[k].vb + cfg[k].vd + cfg[k].vf) mv[k] = 0;
        end
      end
      if (k == 0) qa.push_back(e); else qb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t ea, eb;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL reset_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL reset_b got %h want %h", obs_b, eb); end
    end
    rst_n = 1'b1;
    tick();
    ea = qa.pop_front(); eb = qb.pop_front(); vectors += 3;
    if (obs_a !== ea) begin miscompares++; $display("FAIL reset_rel_a got %h want %h", obs_a, ea); end
    if (obs_b !== eb) begin miscompares++; $display("FAIL reset_rel_b got %h want %h", obs_b, eb); end
    if (fs_a !== 1'b1) begin miscompares++; $display("FAIL reset_rel_fs got %b want 1", fs_a); end
    $display("test_reset done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_bars();
    vec_t ea, eb;
    bit lat_a = 0, lat_b = 0;
    mode = 2'd0;
    for (int i = 0; i < 2 * FA; i++) begin
      tick();
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL bars_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL bars_b got %h want %h", obs_b, eb); end
      if (fs_a) lat_a = 1;
      if (fs_b) lat_b = 1;
      if (lat_a && de_a && (px_a == 11'd0 || px_a == 11'd20 || px_a == 11'd127)) begin
        vectors++;
        if (obs_a[15:0] !== (px_a == 11'd0 ? 16'hFFFF : px_a == 11'd20 ? 16'hFFE0 : 16'h0000)) begin
          miscompares++; $display("FAIL bars_spot_a x=%0d got %h", px_a, obs_a[15:0]);
        end
      end
      if (lat_b && de_b && px_b >= 11'd7) begin
        vectors++;
        if (obs_b[15:0] !== 16'h0000) begin
          miscompares++; $display("FAIL bar7_b x=%0d got %h want 0000", px_b, obs_b[15:0]);
        end
      end
    end
    $display("test_bars done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_grid_checker();
    vec_t ea, eb;
    bit lat_a;
    for (int m = 0; m < 2; m++) begin
      mode = (m == 0) ? 2'd1 : 2'd3;
      lat_a = 0;
      for (int i = 0; i < 2 * FA; i++) begin
        tick();
        ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
        if (obs_a !== ea) begin miscompares++; $display("FAIL pat%0d_a got %h want %h", mode, obs_a, ea); end
        if (obs_b !== eb) begin miscompares++; $display("FAIL pat%0d_b got %h want %h", mode, obs_b, eb); end
        if (fs_a) lat_a = 1;
        if (lat_a && de_a && m == 0 && px_a == 11'd32 && py_a == 11'd5) begin
          vectors++;
          if (obs_a[15:0] !== 16'hFFFF) begin miscompares++; $display("FAIL grid_32_5 got %h want FFFF", obs_a[15:0]); end
        end
        if (lat_a && de_a && m == 1 && px_a == 11'd16 && (py_a == 11'd0 || py_a == 11'd16)) begin
          vectors++;
          if (obs_a[15:0] !== (py_a == 11'd0 ? 16'hFFFF : 16'h0000)) begin
            miscompares++; $display("FAIL checker_16_%0d got %h", py_a, obs_a[15:0]);
          end
        end
      end
    end
    $display("test_grid_checker done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_solid();
    vec_t ea, eb;
    bit seen_fs = 0;
    mode = 2'd2;
    solid_rgb = 16'hF800;
    for (int i = 0; i < FA + FA / 2; i++) begin
      tick();
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL solid_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL solid_b got %h want %h", obs_b, eb); end
    end
    solid_rgb = 16'h001F;
    for (int i = 0; i < FA + 100; i++) begin
      tick();
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL solid2_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL solid2_b got %h want %h", obs_b, eb); end
      if (fs_a) seen_fs = 1;
      if (de_a) begin
        vectors++;
        if (obs_a[15:0] !== (seen_fs ? 16'h001F : 16'hF800)) begin
          miscompares++; $display("FAIL solid_switch got %h after_fs=%0d", obs_a[15:0], seen_fs);
        end
      end
    end
    $display("test_solid done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_small_timing();
    vec_t ea, eb;
    int hs_hi = 0, de_hi = 0, n = 0;
    bit found = 0;
    mode = 2'd0;
    while (!found && n < 3 * FB) begin
      tick(); n++;
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL small_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL small_b got %h want %h", obs_b, eb); end
      found = fs_b;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL small_fs_timeout got none want pulse"); end
    for (int i = 0; i <= FB; i++) begin
      if (i < FB) begin
        if (hs_b) hs_hi++;
        if (de_b) de_hi++;
      end
      if (i == FB) begin
        vectors++;
        if (fs_b !== 1'b1) begin miscompares++; $display("FAIL small_frame_period fs=%b want 1 at 126", fs_b); end
      end else begin
        tick();
        ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
        if (obs_a !== ea) begin miscompares++; $display("FAIL small2_a got %h want %h", obs_a, ea); end
        if (obs_b !== eb) begin miscompares++; $display("FAIL small2_b got %h want %h", obs_b, eb); end
      end
    end
    vectors += 2;
    if (hs_hi !== 14) begin miscompares++; $display("FAIL small_hsync_high got %0d want 14", hs_hi); end
    if (de_hi !== 48) begin miscompares++; $display("FAIL small_de_high got %0d want 48", de_hi); end
    $display("test_small_timing done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  task automatic test_reset_midframe();
    vec_t ea, eb;
    int n = 0, period = 0;
    bit found = 0;
    mode = 2'd3;
    while (mv[0] != 20 && n < 2 * FA) begin
      tick(); n++;
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL mid_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL mid_b got %h want %h", obs_b, eb); end
    end
    rst_n = 1'b0;
    #1;
    vectors += 2;
    if (obs_a !== rst_vec(1'b0)) begin miscompares++; $display("FAIL async_rst_a got %h want %h", obs_a, rst_vec(1'b0)); end
    if (obs_b !== rst_vec(1'b1)) begin miscompares++; $display("FAIL async_rst_b got %h want %h", obs_b, rst_vec(1'b1)); end
    for (int i = 0; i < 3; i++) begin
      tick();
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL in_rst_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL in_rst_b got %h want %h", obs_b, eb); end
    end
    rst_n = 1'b1;
    tick();
    ea = qa.pop_front(); eb = qb.pop_front(); vectors += 3;
    if (obs_a !== ea) begin miscompares++; $display("FAIL rel_a got %h want %h", obs_a, ea); end
    if (obs_b !== eb) begin miscompares++; $display("FAIL rel_b got %h want %h", obs_b, eb); end
    if (fs_a !== 1'b1) begin miscompares++; $display("FAIL rel_fs got %b want 1", fs_a); end
    while (!found && period < 2 * FA) begin
      tick(); period++;
      ea = qa.pop_front(); eb = qb.pop_front(); vectors += 2;
      if (obs_a !== ea) begin miscompares++; $display("FAIL post_a got %h want %h", obs_a, ea); end
      if (obs_b !== eb) begin miscompares++; $display("FAIL post_b got %h want %h", obs_b, eb); end
      found = fs_a;
    end
    vectors++;
    if (period !== FA) begin miscompares++; $display("FAIL post_rst_period got %0d want %0d", period, FA); end
    $display("test_reset_midframe done: vectors=%0d miscompares=%0d", vectors, miscompares);
  endtask

  initial begin
    cfg[0] = '{hs: 8, hb: 4, hd: 128, hf: 4, vs: 2, vb: 2, vd: 36, vf: 1, pol: 1'b0};
    cfg[1] = '{hs: 2, hb: 2, hd: 12, hf: 2, vs: 1, vb: 1, vd: 4, vf: 1, pol: 1'b1};
    for (int k = 0; k < 2; k++) begin
      mh[k] = 0; mv[k] = 0; lm[k] = 2'd0; ls[k] = 16'h0000;
    end
    test_reset();
    test_bars();
    test_grid_checker();
    test_solid();
    test_small_timing();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
